cache_req_master: RTL and testbench

CPU-side request initiator for the cache's processor port. It accepts read/write commands into a small command FIFO and issues them one at a time on the cache's address/read/write lines. It holds each request until the cache drops busywait, then returns read data and a per-access response. It also flags stalls that exceed a timeout and keeps access and stall statistics. It sits between the core/test sequencer and the cache, replacing hand-driven stimulus.

---
 rtl/cache_req_master.sv | 206 ++++++++++++++++++++
 tb/tb_cache_req_master.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_master.sv
// cache_req_master
// ----------------
// CPU-side request initiator for the cache processor port. Commands are
// queued in a small FIFO. The FSM issues them one at a time on the cache
// address/read/write lines and holds each request until busywait drops.
// A request that stalls for TIMEOUT consecutive cycles is aborted.
//
// Ports
//   clk_i, reset_i                 clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o      command handshake into the FIFO
//   cmd_wr_i, cmd_addr_i,
//   cmd_wdata_i                    command type, address and write data
//   c_address_o, c_read_o,
//   c_wr_o, c_wdata_o              request lines to the cache
//   c_busywait_i, c_data_i         cache stall and read data
//   rsp_valid_o, rsp_wr_o,
//   rsp_data_o, rsp_err_o          per-access completion (one-cycle pulse)
//   err_o                          sticky timeout flag
//   acc_cnt_o, stall_cnt_o         saturating access / stall statistics
//
// Handshake: a command is taken on a rising edge where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o depends only on the registered FIFO
// occupancy, never on cmd_valid_i or on a pop in the same cycle.
module cache_req_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic [ADDR_W-1:0] c_address_o,
    output logic              c_read_o,
    output logic              c_wr_o,
    output logic [DATA_W-1:0] c_wdata_o,
    input  logic              c_busywait_i,
    input  logic [DATA_W-1:0] c_data_i,
    output logic              rsp_valid_o,
    output logic              rsp_wr_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  acc_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Command FIFO
    logic [ADDR_W-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_wdata [FIFO_DEPTH];
    logic              r_fifo_wr    [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    // Outstanding request
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic              r_req_wr;
    logic [TMR_W-1:0]  r_timer;

    logic              r_rsp_valid;
    logic              r_rsp_wr;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_err;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_stall;
    logic              w_done;
    logic              w_abort;
    logic [TMR_W-1:0]  w_timer_inc;

    assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_push      = cmd_valid_i && !w_full;
    // Pop uses registered occupancy, so a command pushed this cycle is seen
    // by the FSM one edge later.
    assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
    assign w_stall     = (r_state == ST_BUSY) && c_busywait_i;
    assign w_done      = (r_state == ST_BUSY) && !c_busywait_i;
    assign w_timer_inc = r_timer + 1'b1;
    // The edge that would bring the timer up to TIMEOUT is the abort edge.
    assign w_abort     = w_stall && (w_timer_inc >= TMR_W'(TIMEOUT));

    // FSM: state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_pop) w_state_next = ST_BUSY;
            ST_BUSY: if (w_done || w_abort) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs. Leaving BUSY always passes through IDLE, which guarantees
    // an idle cycle with both request lines low between accesses.
    always_comb begin
        c_read_o    = (r_state == ST_BUSY) && !r_req_wr;
        c_wr_o      = (r_state == ST_BUSY) && r_req_wr;
        c_address_o = r_req_addr;
        c_wdata_o   = r_req_wdata;
    end

    // FIFO storage needs no reset: occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= cmd_addr_i;
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata_i;
            r_fifo_wr[r_wr_ptr]    <= cmd_wr_i;
        end
    end

    // FIFO pointers; PTR_W-bit pointers wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Request, response and statistics datapath
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wr    <= 1'b0;
            r_timer     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_err       <= 1'b0;
            r_acc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_rsp_valid <= w_done || w_abort;
            if (w_pop) begin
                r_req_addr  <= r_fifo_addr[r_rd_ptr];
                r_req_wdata <= r_fifo_wdata[r_rd_ptr];
                r_req_wr    <= r_fifo_wr[r_rd_ptr];
                r_timer     <= '0;
            end
            if (w_stall) begin
                r_timer <= w_timer_inc;
                if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_done) begin
                r_rsp_wr   <= r_req_wr;
                r_rsp_data <= r_req_wr ? '0 : c_data_i;
                r_rsp_err  <= 1'b0;
                if (r_acc_cnt != '1) r_acc_cnt <= r_acc_cnt + 1'b1;
            end
            if (w_abort) begin
                r_rsp_wr   <= r_req_wr;
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
                r_err      <= 1'b1;
            end
        end
    end

    assign cmd_ready_o = !w_full;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_wr_o    = r_rsp_wr;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign err_o       = r_err;
    assign acc_cnt_o   = r_acc_cnt;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_cache_req_master.sv
// Testbench for cache_req_master: behavioural cache model, command driver
// tasks, a response scoreboard and one task per scenario.
module tb_cache_req_master;

    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_wr_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [31:0] c_address_o;
    logic        c_read_o;
    logic        c_wr_o;
    logic [31:0] c_wdata_o;
    logic        c_busywait_i;
    logic [31:0] c_data_i;
    logic        rsp_valid_o;
    logic        rsp_wr_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        err_o;
    logic [CW-1:0] acc_cnt_o;
    logic [CW-1:0] stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Expected response: {wr, err, data}
    logic [33:0] exp_q[$];
    logic [31:0] exp_mem [256];
    bit          exp_written [256];
    int          exp_acc   = 0;
    int          exp_stall = 0;

    // Cache model
    logic [31:0] cmem [256];
    bit          cwritten [256];
    int          stall_cfg = 0;
    bit          stuck = 1'b0;
    int          stall_ctr = 0;
    logic        w_req;

    always #5 clk = ~clk;

    cache_req_master #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(8), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .c_address_o(c_address_o), .c_read_o(c_read_o), .c_wr_o(c_wr_o),
        .c_wdata_o(c_wdata_o), .c_busywait_i(c_busywait_i), .c_data_i(c_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_wr_o(rsp_wr_o), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .err_o(err_o),
        .acc_cnt_o(acc_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return {8'hC0, a, ~a, 8'h5A};
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Cache stalls each request for stall_cfg cycles, or forever while stuck.
    assign w_req        = c_read_o | c_wr_o;
    assign c_busywait_i = w_req && (stuck || (stall_ctr < stall_cfg));
    assign c_data_i     = cwritten[c_address_o[7:0]] ? cmem[c_address_o[7:0]]
                                                     : init_word(c_address_o[7:0]);

    always @(posedge clk) begin
        if (w_req) begin
            if (c_busywait_i) stall_ctr <= stall_ctr + 1;
        end else begin
            stall_ctr <= 0;
        end
        if (c_wr_o && !c_busywait_i) begin
            cmem[c_address_o[7:0]]     <= c_wdata_o;
            cwritten[c_address_o[7:0]] <= 1'b1;
        end
    end

    // Scoreboard: every response pulse is compared with the oldest expectation.
    task automatic monitor_rsp();
        logic [33:0] exp;
        forever begin
            @(negedge clk);
            if (reset_i === 1'b1 && rsp_valid_o === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rsp_unexpected: got wr=%0b err=%0b data=%h, expected no response",
                             rsp_wr_o, rsp_err_o, rsp_data_o);
                end else begin
                    exp = exp_q.pop_front();
                    if ({rsp_wr_o, rsp_err_o, rsp_data_o} !== exp) begin
                        n_errors++;
                        $display("FAIL rsp_match: got wr=%0b err=%0b data=%h, expected wr=%0b err=%0b data=%h",
                                 rsp_wr_o, rsp_err_o, rsp_data_o, exp[33], exp[32], exp[31:0]);
                    end
                end
            end
        end
    endtask

    // Drives one command, waits for ready, records the expected response.
    task automatic drive_cmd(input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input bit exp_err);
        int waited = 0;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_wr_i    = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = data;
        while (!cmd_ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_wait: cmd_ready_o stayed 0 for %0d cycles, expected 1", waited);
            cmd_valid_i = 1'b0;
        end else begin
            if (exp_err) begin
                exp_q.push_back({wr, 1'b1, 32'h0});
            end else if (wr) begin
                exp_q.push_back({1'b1, 1'b0, 32'h0});
                exp_mem[addr[7:0]]     = data;
                exp_written[addr[7:0]] = 1'b1;
            end else begin
                exp_q.push_back({1'b0, 1'b0,
                    exp_written[addr[7:0]] ? exp_mem[addr[7:0]] : init_word(addr[7:0])});
            end
            @(posedge clk);
        end
    endtask

    task automatic end_cmds();
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((exp_q.size() != 0 || w_req) && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || w_req) begin
            n_errors++;
            $display("FAIL idle_wait: %0d responses outstanding, req=%0b, expected 0 and 0",
                     exp_q.size(), w_req);
        end
    endtask

    task automatic check_counters(input string name);
        n_checks++;
        if (acc_cnt_o !== CW'(sat(exp_acc)) || stall_cnt_o !== CW'(sat(exp_stall))) begin
            n_errors++;
            $display("FAIL %s_counters: got acc=%0d stall=%0d, expected acc=%0d stall=%0d",
                     name, acc_cnt_o, stall_cnt_o, sat(exp_acc), sat(exp_stall));
        end
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if (cmd_ready_o !== 1'b1 || c_read_o !== 1'b0 || c_wr_o !== 1'b0 ||
            rsp_valid_o !== 1'b0 || err_o !== 1'b0 || acc_cnt_o !== '0 ||
            stall_cnt_o !== '0 || c_address_o !== '0 || rsp_data_o !== '0) begin
            n_errors++;
            $display("FAIL %s: got ready=%0b rd=%0b wr=%0b rv=%0b err=%0b acc=%0d stall=%0d addr=%h, expected 1 0 0 0 0 0 0 0",
                     name, cmd_ready_o, c_read_o, c_wr_o, rsp_valid_o, err_o,
                     acc_cnt_o, stall_cnt_o, c_address_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_wr_i = 1'b0;
        cmd_addr_i = '0;
        cmd_wdata_i = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset_hold");
        reset_i = 1'b1;
        repeat (5) @(negedge clk);
        check_quiet("reset_idle");
    endtask

    task automatic test_read_hit();
        stall_cfg = 0;
        drive_cmd(1'b0, 32'h0A, 32'h0, 1'b0);
        end_cmds();
        n_checks++;
        if (c_read_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hit_early: c_read_o=%0b one cycle after push, expected 0", c_read_o);
        end
        @(negedge clk);
        n_checks++;
        if (c_read_o !== 1'b1 || c_wr_o !== 1'b0 || c_address_o !== 32'h0A) begin
            n_errors++;
            $display("FAIL hit_issue: got rd=%0b wr=%0b addr=%h, expected 1 0 0000000a",
                     c_read_o, c_wr_o, c_address_o);
        end
        @(negedge clk);
        n_checks++;
        if (c_read_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL hit_complete: got rd=%0b rsp_valid=%0b, expected 0 1", c_read_o, rsp_valid_o);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hit_pulse: rsp_valid_o=%0b a cycle later, expected 0", rsp_valid_o);
        end
        exp_acc += 1;
        check_counters("hit");
    endtask

    task automatic test_read_miss();
        int hi = 0;
        bit addr_ok = 1'b1;
        bit seen = 1'b0;
        bit timing_ok = 1'b0;
        stall_cfg = 5;
        drive_cmd(1'b0, 32'h2, 32'h0, 1'b0);
        end_cmds();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_read_o) begin
                hi++;
                if (c_address_o !== 32'h2) addr_ok = 1'b0;
            end
            if (rsp_valid_o && !seen) begin
                seen = 1'b1;
                timing_ok = (hi == 6) && !c_read_o;
            end
        end
        n_checks++;
        if (hi != 6 || !addr_ok || !timing_ok) begin
            n_errors++;
            $display("FAIL miss_hold: got read cycles=%0d addr_stable=%0b rsp_timing=%0b, expected 6 1 1",
                     hi, addr_ok, timing_ok);
        end
        exp_acc += 1;
        exp_stall += 5;
        check_counters("miss");
    endtask

    task automatic test_back_to_back();
        int last_wr = -1;
        int first_rd = -1;
        bit overlap = 1'b0;
        stall_cfg = 0;
        drive_cmd(1'b1, 32'h4, 32'hDEADBEEF, 1'b0);
        drive_cmd(1'b0, 32'h4, 32'h0, 1'b0);
        end_cmds();
        for (int i = 0; i < 12; i++) begin
            if (c_wr_o && c_read_o) overlap = 1'b1;
            if (c_wr_o) last_wr = i;
            if (c_read_o && first_rd < 0) first_rd = i;
            @(negedge clk);
        end
        n_checks++;
        if (overlap || last_wr < 0 || first_rd < 0 || first_rd <= last_wr + 1) begin
            n_errors++;
            $display("FAIL b2b_gap: got last_wr=%0d first_rd=%0d overlap=%0b, expected write, idle gap, read",
                     last_wr, first_rd, overlap);
        end
        wait_idle();
        exp_acc += 2;
        check_counters("b2b");
    endtask

    task automatic test_fifo_full();
        stall_cfg = 7;
        drive_cmd(1'b1, 32'h30, 32'h11111111, 1'b0);
        drive_cmd(1'b0, 32'h30, 32'h0, 1'b0);
        drive_cmd(1'b1, 32'h31, 32'h22222222, 1'b0);
        drive_cmd(1'b0, 32'h31, 32'h0, 1'b0);
        drive_cmd(1'b0, 32'h32, 32'h0, 1'b0);
        end_cmds();
        n_checks++;
        if (cmd_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL fifo_full: cmd_ready_o=%0b with 4 queued, expected 0", cmd_ready_o);
        end
        drive_cmd(1'b0, 32'h33, 32'h0, 1'b0);
        end_cmds();
        wait_idle();
        exp_acc += 6;
        exp_stall += 42;
        check_counters("fifo");
    endtask

    task automatic test_timeout();
        int hi = 0;
        int cyc = 0;
        stall_cfg = 0;
        stuck = 1'b1;
        drive_cmd(1'b0, 32'h40, 32'h0, 1'b1);
        drive_cmd(1'b1, 32'h41, 32'h33333333, 1'b0);
        end_cmds();
        while (!rsp_valid_o && cyc < 40) begin
            if (c_read_o) hi++;
            @(negedge clk);
            cyc++;
        end
        stuck = 1'b0;
        n_checks++;
        if (!rsp_valid_o || hi != 8 || err_o !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_abort: got rsp_valid=%0b stalled cycles=%0d err=%0b, expected 1 8 1",
                     rsp_valid_o, hi, err_o);
        end
        wait_idle();
        drive_cmd(1'b0, 32'h41, 32'h0, 1'b0);
        end_cmds();
        wait_idle();
        n_checks++;
        if (err_o !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky: err_o=%0b, expected 1", err_o);
        end
        exp_acc += 2;
        exp_stall += 8;
        check_counters("timeout");
    endtask

    task automatic test_saturate();
        stall_cfg = 7;
        for (int i = 0; i < 40; i++) begin
            drive_cmd(1'b0, 32'h80 + i, 32'h0, 1'b0);
        end
        end_cmds();
        wait_idle();
        exp_acc += 40;
        exp_stall += 280;
        check_counters("saturate");
    endtask

    task automatic test_reset_mid_stall();
        int req_seen = 0;
        stall_cfg = 0;
        stuck = 1'b1;
        drive_cmd(1'b0, 32'h50, 32'h0, 1'b0);
        drive_cmd(1'b0, 32'h51, 32'h0, 1'b0);
        end_cmds();
        repeat (3) @(negedge clk);
        #2;
        reset_i = 1'b0;
        #1;
        exp_q.delete();
        check_quiet("reset_async");
        stuck = 1'b0;
        @(negedge clk);
        reset_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (w_req || rsp_valid_o) req_seen++;
        end
        n_checks++;
        if (req_seen != 0) begin
            n_errors++;
            $display("FAIL reset_flush: %0d active cycles after reset, expected 0", req_seen);
        end
        exp_acc = 0;
        exp_stall = 0;
        drive_cmd(1'b0, 32'h0A, 32'h0, 1'b0);
        end_cmds();
        wait_idle();
        exp_acc += 1;
        check_counters("after_reset");
    endtask

    initial begin
        fork
            monitor_rsp();
        join_none
        test_reset();
        test_read_hit();
        test_read_miss();
        test_back_to_back();
        test_fifo_full();
        test_timeout();
        test_saturate();
        test_reset_mid_stall();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
